// File: rtl/control_fsm_pkg.sv
// ============================================================================
// control_fsm_pkg : shared encodings for the multicycle control FSM.
// Rev 1.0
// ============================================================================
`default_nettype none

package control_fsm_pkg;

   typedef enum logic [3:0] {
      ST_FETCH    = 4'd0,
      ST_DECODE   = 4'd1,
      ST_MEMADR   = 4'd2,
      ST_MEMREAD  = 4'd3,
      ST_MEMWB    = 4'd4,
      ST_MEMWRITE = 4'd5,
      ST_EXECUTER = 4'd6,
      ST_EXECUTEI = 4'd7,
      ST_ALUWB    = 4'd8,
      ST_BEQ      = 4'd9,
      ST_JAL      = 4'd10,
      ST_ILLEGAL  = 4'd11
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   // Shared with the ALU decoder.
   localparam logic [1:0] ALU_OP_ADD   = 2'b00;
   localparam logic [1:0] ALU_OP_SUB   = 2'b01;
   localparam logic [1:0] ALU_OP_RTYPE = 2'b10;
   localparam logic [1:0] ALU_OP_ITYPE = 2'b11;

   localparam logic [1:0] SRC_A_PC     = 2'b00;
   localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
   localparam logic [1:0] SRC_A_RS1    = 2'b10;

   localparam logic [1:0] SRC_B_RS2    = 2'b00;
   localparam logic [1:0] SRC_B_IMM    = 2'b01;
   localparam logic [1:0] SRC_B_FOUR   = 2'b10;

   localparam logic [1:0] RES_ALU_OUT  = 2'b00;
   localparam logic [1:0] RES_MEM_DATA = 2'b01;
   localparam logic [1:0] RES_ALU_RES  = 2'b10;

endpackage

`default_nettype wire

// File: rtl/control_fsm.sv
// ============================================================================
// control_fsm : multicycle RISC-V style control unit (state register,
//               next-state logic and Moore output decode).
// Rev 1.0
// ============================================================================
`default_nettype none

module control_fsm
   import control_fsm_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       adr_src,
   output logic       ir_write,
   output logic       pc_write,
   output logic       reg_write,
   output logic       mem_write,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] result_src,
   output logic       illegal_instr,
   output logic [3:0] state_o
);

   state_t r_state;
   state_t w_next;
   logic   r_active;

   // r_active holds every output at zero from reset release until the first clk edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_FETCH;
         r_active <= 1'b0;
      end else begin
         r_state  <= w_next;
         r_active <= 1'b1;
      end
   end

   always_comb begin
      w_next = ST_FETCH;
      if (r_active) begin
         case (r_state)
            ST_FETCH:    w_next = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
               case (opcode)
                  OP_LOAD, OP_STORE: w_next = ST_MEMADR;
                  OP_RTYPE:          w_next = ST_EXECUTER;
                  OP_ITYPE:          w_next = ST_EXECUTEI;
                  OP_BRANCH:         w_next = ST_BEQ;
                  OP_JAL:            w_next = ST_JAL;
                  default:           w_next = ST_ILLEGAL;
               endcase
            end
            ST_MEMADR:   w_next = (opcode == OP_LOAD) ? ST_MEMREAD : ST_MEMWRITE;
            ST_MEMREAD:  w_next = mem_ready ? ST_MEMWB : ST_MEMREAD;
            ST_MEMWB:    w_next = ST_FETCH;
            ST_MEMWRITE: w_next = mem_ready ? ST_FETCH : ST_MEMWRITE;
            ST_EXECUTER: w_next = ST_ALUWB;
            ST_EXECUTEI: w_next = ST_ALUWB;
            ST_ALUWB:    w_next = ST_FETCH;
            ST_BEQ:      w_next = ST_FETCH;
            ST_JAL:      w_next = ST_ALUWB;
            ST_ILLEGAL:  w_next = ST_ILLEGAL;
            default:     w_next = ST_FETCH;
         endcase
      end
   end

   always_comb begin
      mem_req       = 1'b0;
      adr_src       = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      reg_write     = 1'b0;
      mem_write     = 1'b0;
      alu_src_a     = SRC_A_PC;
      alu_src_b     = SRC_B_RS2;
      alu_op        = ALU_OP_ADD;
      result_src    = RES_ALU_OUT;
      illegal_instr = 1'b0;
      if (rst_n && r_active) begin
         case (r_state)
            ST_FETCH: begin
               mem_req    = 1'b1;
               alu_src_b  = SRC_B_FOUR;
               result_src = RES_ALU_RES;
               ir_write   = mem_ready;
               pc_write   = mem_ready;
            end
            ST_DECODE: begin
               alu_src_a = SRC_A_OLD_PC;
               alu_src_b = SRC_B_IMM;
            end
            ST_MEMADR: begin
               alu_src_a = SRC_A_RS1;
               alu_src_b = SRC_B_IMM;
            end
            ST_MEMREAD: begin
               mem_req = 1'b1;
               adr_src = 1'b1;
            end
            ST_MEMWB: begin
               result_src = RES_MEM_DATA;
               reg_write  = 1'b1;
            end
            ST_MEMWRITE: begin
               mem_req   = 1'b1;
               adr_src   = 1'b1;
               mem_write = 1'b1;
            end
            ST_EXECUTER: begin
               alu_src_a = SRC_A_RS1;
               alu_op    = ALU_OP_RTYPE;
            end
            ST_EXECUTEI: begin
               alu_src_a = SRC_A_RS1;
               alu_src_b = SRC_B_IMM;
               alu_op    = ALU_OP_ITYPE;
            end
            ST_ALUWB:   reg_write = 1'b1;
            ST_BEQ: begin
               alu_src_a = SRC_A_RS1;
               alu_op    = ALU_OP_SUB;
               pc_write  = zero;
            end
            ST_JAL: begin
               alu_src_a = SRC_A_OLD_PC;
               alu_src_b = SRC_B_FOUR;
               pc_write  = 1'b1;
            end
            ST_ILLEGAL: illegal_instr = 1'b1;
            default: ;
         endcase
      end
   end

   assign state_o = r_state;

endmodule

`default_nettype wire

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset. Ports: clk (rising edge) and rst_n (asynchronous, active-low).
REQ-002 clk  input  1  system clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 opcode  input  7  instruction[6:0] from the instruction register; stable from DECODE until the next FETCH.
REQ-005 zero  input  1  ALU zero flag.
REQ-006 mem_ready  input  1  memory completes the current access this cycle.
REQ-007 mem_req  output  1  memory access request.
REQ-008 adr_src  output  1  memory address select: 0 = PC, 1 = ALU-out register.
REQ-009 ir_write, pc_write, reg_write, mem_write  output  1 each  write enables.
REQ-010 alu_src_a  output  2  operand A select: 00 = PC, 01 = old PC, 10 = rs1.
REQ-011 alu_src_b  output  2  operand B select: 00 = rs2, 01 = immediate, 10 = constant 4.
REQ-012 alu_op  output  2  encoding: 00 = ADD, 01 = SUB, 10 = R-type, 11 = I-type; feeds the ALU decoder.
REQ-013 result_src  output  2  result select: 00 = ALU-out register, 01 = memory data, 10 = ALU result.
REQ-014 illegal_instr  output  1  sticky unsupported-opcode flag.
REQ-015 state_o  output  4  current state, for debug.

Function
REQ-016 State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10, ILLEGAL=11; codes 12-15 SHALL transition to FETCH.
REQ-017 Output default in every state: all outputs SHALL be 0 unless listed for that state below.
REQ-018 FETCH: mem_req=1, alu_src_b=10, result_src=10, ir_write=pc_write=mem_ready. Holds while mem_ready=0; goes to DECODE when mem_ready=1.
REQ-019 DECODE: alu_src_a=01, alu_src_b=01 (branch target). Next state by opcode: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1100011 -> BEQ; 1101111 -> JAL; any other opcode -> ILLEGAL.
REQ-020 MEMADR: alu_src_a=10, alu_src_b=01. Next: opcode 0000011 -> MEMREAD, otherwise MEMWRITE.
REQ-021 MEMREAD: mem_req=1, adr_src=1. Holds while mem_ready=0, then goes to MEMWB.
REQ-022 MEMWB: result_src=01, reg_write=1, then FETCH.
REQ-023 MEMWRITE: mem_req=1, adr_src=1, mem_write=1, held through the stall. Goes to FETCH when mem_ready=1.
REQ-024 EXECUTER: alu_src_a=10, alu_op=10, then ALUWB.
REQ-025 EXECUTEI: alu_src_a=10, alu_src_b=01, alu_op=11, then ALUWB.
REQ-026 ALUWB: reg_write=1, then FETCH.
REQ-027 BEQ: alu_src_a=10, alu_op=01, pc_write=zero, then FETCH.
REQ-028 JAL: alu_src_a=01, alu_src_b=10, pc_write=1, then ALUWB.
REQ-029 ILLEGAL: terminal state; illegal_instr=1; all enables and mem_req SHALL stay 0 until reset.
REQ-030 Outputs SHALL be Moore-decoded from state, except ir_write/pc_write in FETCH (gated by mem_ready) and pc_write in BEQ (gated by zero).
REQ-031 Unstalled cycle counts: R/I-type 4, lw 5, sw 4, beq 3, jal 4.
REQ-032 mem_ready SHALL be ignored outside FETCH, MEMREAD and MEMWRITE.

Reset
REQ-033 rst_n low SHALL force state FETCH immediately, regardless of clk.
REQ-034 While rst_n is low, all outputs SHALL be held at 0, including mem_req, and illegal_instr SHALL be cleared.
REQ-035 Assertion of rst_n in any state, including mid-stall, SHALL abandon the access without a write.
REQ-036 FETCH output decode SHALL resume on the first clk edge after rst_n is released.

Structure
REQ-037 A shared package SHALL hold the state encodings, opcode constants, and the alu_op, alu_src_a/b and result_src encodings; the ALU decoder SHALL share the alu_op encodings.
REQ-038 The block SHALL be one module (state register, next-state logic, output decode) with no sub-module; immediate-select decoding is out of scope.

Verification
REQ-039 Reset assertion during a MEMREAD stall -> state_o=0 and outputs 0 while low; after release, FETCH with mem_req=1 and no reg_write pulse.
REQ-040 R-type add (opcode 0110011), mem_ready=1 -> state sequence 0,1,6,8,0; alu_op=10 in EXECUTER; exactly one reg_write pulse.
REQ-041 lw (0000011) with mem_ready low for 3 cycles in MEMREAD -> MEMREAD held 4 cycles; 8 cycles total; result_src=01 in MEMWB.
REQ-042 sw (0100011) with a 2-cycle FETCH stall -> ir_write/pc_write low until mem_ready=1; mem_write held high for the whole MEMWRITE stay.
REQ-043 beq (1100011) with zero=1, then zero=0 -> pc_write=1, then pc_write=0 in BEQ; alu_op=01 in both.
REQ-044 opcode 0000000 -> DECODE then ILLEGAL; illegal_instr=1 and mem_req=0 for 20+ cycles until rst_n is pulsed.
